// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: 2-bit counter encoding,
// the init/run state enum and the saturating counter step function.
package branch_predictor_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_bp_ctr;

    localparam lc3b_bp_ctr BP_STRONG_NT = 2'b00;
    localparam lc3b_bp_ctr BP_WEAK_NT   = 2'b01;
    localparam lc3b_bp_ctr BP_WEAK_T    = 2'b10;
    localparam lc3b_bp_ctr BP_STRONG_T  = 2'b11;

    typedef enum logic {
        bp_init,
        bp_run
    } lc3b_bp_state;

    // Saturating step toward the resolved outcome; never wraps.
    function automatic lc3b_bp_ctr bp_ctr_next(input lc3b_bp_ctr ctr, input logic taken);
        lc3b_bp_ctr result;
        result = ctr;
        if (taken) begin
            if (ctr != BP_STRONG_T) result = ctr + 2'd1;
        end else begin
            if (ctr != BP_STRONG_NT) result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_predictor_bp_counter_array.sv
// Table of 2^IDX_BITS two-bit counters: one combinational read port, one
// read-modify-write training port and a sweep-write port used during init.
module bp_counter_array
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic [IDX_BITS-1:0] rd_idx,
    output lc3b_bp_ctr          rd_ctr,
    input  logic                upd_en,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic                sweep_en,
    input  logic [IDX_BITS-1:0] sweep_idx
);

    localparam int ENTRIES = 1 << IDX_BITS;

    lc3b_bp_ctr ctr_reg [ENTRIES];

    // Read is from the current array contents, so a same-cycle update to the
    // same entry is only seen from the following cycle.
    assign rd_ctr = ctr_reg[rd_idx];

    always_ff @(posedge clk) begin
        if (sweep_en) begin
            ctr_reg[sweep_idx] <= BP_WEAK_NT;
        end else if (upd_en) begin
            ctr_reg[upd_idx] <= bp_ctr_next(ctr_reg[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit branch predictor with init sweep and mispredict counter.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history register into the index.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  lc3b_word         fetch_pc,
    output logic             predict_taken,
    output logic             predict_ready,
    input  logic             update_valid,
    input  lc3b_word         update_pc,
    input  logic             update_taken,
    input  logic             update_predicted,
    output logic [CNT_W-1:0] mispredict_count
);

    lc3b_bp_state        state_reg, state_next;
    logic [IDX_BITS-1:0] sweep_reg, sweep_next;
    logic [CNT_W-1:0]    mispredict_count_reg, mispredict_count_next;

    logic                in_run;
    logic                upd_en;
    logic [IDX_BITS-1:0] fetch_idx;
    logic [IDX_BITS-1:0] update_idx;
    lc3b_bp_ctr          rd_ctr;
    logic                pc_unused;

    assign in_run = (state_reg == bp_run);
    assign upd_en = in_run && update_valid;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_reg, ghr_next;

    // Both paths hash with the history as it stands before this update shifts in.
    assign fetch_idx  = fetch_pc[IDX_BITS:1] ^ ghr_reg;
    assign update_idx = update_pc[IDX_BITS:1] ^ ghr_reg;

    always_comb begin
        ghr_next = ghr_reg;
        if (upd_en) ghr_next = {ghr_reg[IDX_BITS-2:0], update_taken};
    end

    always_ff @(posedge clk) begin
        if (reset) ghr_reg <= '0;
        else       ghr_reg <= ghr_next;
    end
`else
    assign fetch_idx  = fetch_pc[IDX_BITS:1];
    assign update_idx = update_pc[IDX_BITS:1];
`endif

    assign pc_unused = ^{fetch_pc[15:IDX_BITS+1], fetch_pc[0],
                         update_pc[15:IDX_BITS+1], update_pc[0]};

    always_comb begin
        state_next            = state_reg;
        sweep_next            = sweep_reg;
        mispredict_count_next = mispredict_count_reg;
        unique case (state_reg)
            bp_init: begin
                sweep_next = sweep_reg + IDX_BITS'(1);
                if (sweep_reg == '1) state_next = bp_run;
            end
            bp_run: begin
                if (update_valid && (update_taken != update_predicted)
                    && (mispredict_count_reg != '1)) begin
                    mispredict_count_next = mispredict_count_reg + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg            <= bp_init;
            sweep_reg            <= '0;
            mispredict_count_reg <= '0;
        end else begin
            state_reg            <= state_next;
            sweep_reg            <= sweep_next;
            mispredict_count_reg <= mispredict_count_next;
        end
    end

    bp_counter_array #(
        .IDX_BITS (IDX_BITS)
    ) u_counter_array (
        .clk       (clk),
        .rd_idx    (fetch_idx),
        .rd_ctr    (rd_ctr),
        .upd_en    (upd_en),
        .upd_idx   (update_idx),
        .upd_taken (update_taken),
        .sweep_en  (state_reg == bp_init),
        .sweep_idx (sweep_reg)
    );

    // Outputs held at zero while the table is still being swept.
    assign predict_ready    = in_run;
    assign predict_taken    = in_run && rd_ctr[1];
    assign mispredict_count = mispredict_count_reg;

endmodule
